// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder using a single full-adder slice and one carry flop
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         cout
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t         state, state_n;
  logic [N-1:0]   a_sr, b_sr, r_sr;
  logic           c;
  logic [CW-1:0]  cnt;
  logic           sb, cn, last;
  assign sb   = a_sr[0] ^ b_sr[0] ^ c;
  assign cn   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  assign last = cnt == CW'(N - 1);
  assign busy = state == ADD;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  // next state: ADD runs for exactly N bits, DONE lasts one cycle
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? ADD : IDLE) :
              state == ADD  ? (last ? DONE : ADD) : IDLE;
  end
  // datapath: operand capture, one full-adder slice per cycle, result load on final bit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr <= A;
      b_sr <= B;
      c    <= cin;
      cnt  <= '0;
    end else if (state == ADD) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= {sb, r_sr[N-1:1]};
      c    <= cn;
      cnt  <= cnt + CW'(1);
      if (last) begin
        S    <= {sb, r_sr[N-1:1]};
        cout <= cn;
      end
    end
endmodule
